// File: rtl/median3x3_bram_reader_if.sv
// Bus bundle between the median reader and its neighbours: the BRAM read port
// (en/addr/dout) and the valid/ready median output stream.
interface median3x3_bram_reader_if #(
  parameter int BIT_WIDTH  = 8,
  parameter int ADDR_WIDTH = 18
) ();
  logic                  mem_en;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [BIT_WIDTH-1:0]  mem_dout;
  logic                  out_valid;
  logic                  out_ready;
  logic [BIT_WIDTH-1:0]  out_data;
  logic [ADDR_WIDTH-1:0] out_addr;
  logic                  out_last;

  modport master (
    output mem_en, mem_addr, out_valid, out_data, out_addr, out_last,
    input  mem_dout, out_ready
  );

  modport slave (
    input  mem_en, mem_addr, out_valid, out_data, out_addr, out_last,
    output mem_dout, out_ready
  );
endinterface

// File: rtl/median3x3_bram_reader.sv
// Walks a W x H image held in a single-port BRAM in raster order and streams the
// median of each pixel's edge-replicated 3x3 neighbourhood.
module median3x3_bram_reader #(
  parameter int BIT_WIDTH  = 8,
  parameter int IMG_W_LOG2 = 9,
  parameter int IMG_H_LOG2 = 9,
  parameter int ADDR_WIDTH = 18,
  parameter int RD_LAT     = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  output logic busy,
  output logic done,
  median3x3_bram_reader_if.master bus
);
  localparam logic [IMG_W_LOG2-1:0] X_ZERO = {IMG_W_LOG2{1'b0}};
  localparam logic [IMG_W_LOG2-1:0] X_MAX  = {IMG_W_LOG2{1'b1}};
  localparam logic [IMG_W_LOG2-1:0] X_ONE  = IMG_W_LOG2'(1'b1);
  localparam logic [IMG_H_LOG2-1:0] Y_ZERO = {IMG_H_LOG2{1'b0}};
  localparam logic [IMG_H_LOG2-1:0] Y_MAX  = {IMG_H_LOG2{1'b1}};
  localparam logic [IMG_H_LOG2-1:0] Y_ONE  = IMG_H_LOG2'(1'b1);
  localparam logic [1:0]            D_LAST = 2'(RD_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_DRAIN = 3'd2,
    S_SORT  = 3'd3,
    S_OUT   = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t                          state_r, state_nxt_s;
  logic [IMG_W_LOG2-1:0]           x_r, x_nxt_s;
  logic [IMG_H_LOG2-1:0]           y_r, y_nxt_s;
  logic [3:0]                      k_r, k_nxt_s;
  logic [1:0]                      d_r, d_nxt_s;
  logic [8:0][BIT_WIDTH-1:0]       taps_r;
  logic [RD_LAT-1:0]               pipe_v_r;
  logic [RD_LAT-1:0][3:0]          pipe_k_r;

  // Address of tap k (row-major dy outer, dx inner) with coordinates clamped to the image.
  function automatic logic [ADDR_WIDTH-1:0] tap_addr(input logic [IMG_W_LOG2-1:0] px,
                                                     input logic [IMG_H_LOG2-1:0] py,
                                                     input logic [3:0] k);
    logic [IMG_W_LOG2-1:0] xm, xp, tx;
    logic [IMG_H_LOG2-1:0] ym, yp, ty;
    xm = (px == X_ZERO) ? px : px - X_ONE;
    xp = (px == X_MAX)  ? px : px + X_ONE;
    ym = (py == Y_ZERO) ? py : py - Y_ONE;
    yp = (py == Y_MAX)  ? py : py + Y_ONE;
    case (k)
      4'd0:    begin ty = ym; tx = xm; end
      4'd1:    begin ty = ym; tx = px; end
      4'd2:    begin ty = ym; tx = xp; end
      4'd3:    begin ty = py; tx = xm; end
      4'd4:    begin ty = py; tx = px; end
      4'd5:    begin ty = py; tx = xp; end
      4'd6:    begin ty = yp; tx = xm; end
      4'd7:    begin ty = yp; tx = px; end
      4'd8:    begin ty = yp; tx = xp; end
      default: begin ty = py; tx = px; end
    endcase
    return {ty, tx};
  endfunction

  // Tap of rank 4 wins; equal values are ranked by index so duplicates count individually.
  function automatic logic [BIT_WIDTH-1:0] med9(input logic [8:0][BIT_WIDTH-1:0] t);
    logic [BIT_WIDTH-1:0] m;
    logic [3:0]           rank;
    m = t[0];
    for (int i = 0; i < 9; i++) begin
      rank = 4'd0;
      for (int j = 0; j < 9; j++) begin
        if ((t[j] < t[i]) || ((t[j] == t[i]) && (j < i))) begin
          rank = rank + 4'd1;
        end
      end
      if (rank == 4'd4) begin
        m = t[i];
      end
    end
    return m;
  endfunction

  // Next-state and pixel/tap counter logic.
  always_comb begin
    state_nxt_s = state_r;
    x_nxt_s     = x_r;
    y_nxt_s     = y_r;
    k_nxt_s     = k_r;
    d_nxt_s     = d_r;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          state_nxt_s = S_FETCH;
          x_nxt_s     = X_ZERO;
          y_nxt_s     = Y_ZERO;
          k_nxt_s     = 4'd0;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_FETCH: begin
        if (k_r == 4'd8) begin
          state_nxt_s = S_DRAIN;
          d_nxt_s     = 2'd0;
        end else begin
          k_nxt_s = k_r + 4'd1;
        end
      end
      S_DRAIN: begin
        if (d_r == D_LAST) begin
          state_nxt_s = S_SORT;
        end else begin
          d_nxt_s = d_r + 2'd1;
        end
      end
      S_SORT: state_nxt_s = S_OUT;
      S_OUT: begin
        if (bus.out_ready) begin
          if (bus.out_last) begin
            state_nxt_s = S_DONE;
          end else begin
            state_nxt_s = S_FETCH;
            k_nxt_s     = 4'd0;
            if (x_r == X_MAX) begin
              x_nxt_s = X_ZERO;
              y_nxt_s = y_r + Y_ONE;
            end else begin
              x_nxt_s = x_r + X_ONE;
            end
          end
        end else begin
          state_nxt_s = S_OUT;
        end
      end
      S_DONE:  state_nxt_s = S_IDLE;
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Registered outputs, counters, read-latency tracking and tap capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_r           <= X_ZERO;
      y_r           <= Y_ZERO;
      k_r           <= 4'd0;
      d_r           <= 2'd0;
      taps_r        <= '0;
      pipe_v_r      <= '0;
      pipe_k_r      <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      bus.mem_en    <= 1'b0;
      bus.mem_addr  <= {ADDR_WIDTH{1'b0}};
      bus.out_valid <= 1'b0;
      bus.out_data  <= {BIT_WIDTH{1'b0}};
      bus.out_addr  <= {ADDR_WIDTH{1'b0}};
      bus.out_last  <= 1'b0;
    end else begin
      x_r           <= x_nxt_s;
      y_r           <= y_nxt_s;
      k_r           <= k_nxt_s;
      d_r           <= d_nxt_s;
      busy          <= (state_nxt_s == S_FETCH) || (state_nxt_s == S_DRAIN) ||
                       (state_nxt_s == S_SORT)  || (state_nxt_s == S_OUT);
      done          <= (state_nxt_s == S_DONE);
      bus.mem_en    <= (state_nxt_s == S_FETCH);
      bus.out_valid <= (state_nxt_s == S_OUT);
      if (state_nxt_s == S_FETCH) begin
        bus.mem_addr <= tap_addr(x_nxt_s, y_nxt_s, k_nxt_s);
      end
      // The word for an address shows up RD_LAT edges after the BRAM sampled it.
      if (pipe_v_r[RD_LAT-1]) begin
        taps_r[pipe_k_r[RD_LAT-1]] <= bus.mem_dout;
      end
      for (int i = RD_LAT - 1; i > 0; i--) begin
        pipe_v_r[i] <= pipe_v_r[i-1];
        pipe_k_r[i] <= pipe_k_r[i-1];
      end
      pipe_v_r[0] <= bus.mem_en;
      pipe_k_r[0] <= k_r;
      if (state_r == S_SORT) begin
        bus.out_data <= med9(taps_r);
        bus.out_addr <= {y_r, x_r};
        bus.out_last <= (x_r == X_MAX) && (y_r == Y_MAX);
      end
    end
  end
endmodule
